mdu_sequencer: RTL and testbench
================================

Name: mdu_sequencer

Overview:
Multi-cycle sequencer for the RV32M multiply/divide operations. It sits beside the single-cycle ALU.
- Accepts an operation when the control unit decodes opcode 0110011 with funct7 = 0000001.
- Stalls the PC and register-file write while it iterates.
- Presents a 32-bit result in its final cycle so the core commits the instruction.
- Contains a controller FSM that drives an iterative shift/add-subtract datapath.

Parameters:
- DATA_WIDTH, 32: operand/result width in bits.
- CNT_WIDTH, 5: iteration counter width, equal to clog2(DATA_WIDTH).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start_i  input  1  M-extension instruction present in decode; sampled only in IDLE.
- funct3_i  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rs1_data_i  input  DATA_WIDTH  multiplicand/dividend; must be held stable while stall_o is high.
- rs2_data_i  input  DATA_WIDTH  multiplier/divisor; must be held stable while stall_o is high.
- stall_o  output  1  combinational; freezes PC and register-file write.
- busy_o  output  1  high whenever the FSM is not in IDLE.
- done_o  output  1  one-cycle pulse; result_o is valid and the instruction commits.
- result_o  output  DATA_WIDTH  final result; holds its value until the next accepted start.

Behaviour:
- Reset (async, active-high):
  - FSM to IDLE.
  - Counter, accumulator, operand registers and result_o cleared to 0.
  - busy_o = 0, done_o = 0, stall_o = 0 (while start_i is low).
  - Reset mid-operation aborts the operation; no partial result is emitted.
- States:
  - IDLE: waits for start_i.
  - PREP: latches funct3; takes operand absolute values for signed ops and records result/remainder signs; detects special cases.
  - CALC: one iteration per cycle. Multiply uses shift-add on a 2*DATA_WIDTH product register. Divide uses restoring shift-subtract.
  - FIX: applies sign correction; selects low/high product half or quotient/remainder.
  - DONE: drives done_o.
- Transitions:
  - IDLE -> PREP on start_i.
  - PREP -> CALC.
  - CALC -> FIX when counter = DATA_WIDTH-1.
  - FIX -> DONE.
  - DONE -> IDLE unconditionally.
- Timing (start sampled at cycle 0):
  - PREP at cycle 1.
  - CALC at cycles 2..33.
  - FIX at cycle 34.
  - DONE at cycle 35, so done_o = 1 at cycle 35.
- stall_o = (IDLE && start_i) || PREP || CALC || FIX. It is low in DONE, so the PC advances and the write-back occurs in that cycle.
- start_i while not in IDLE is ignored; no queueing.
- A back-to-back start in the cycle after DONE is accepted normally.
- Signedness:
  - MULH: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - MULHU, DIVU, REMU: unsigned.
  - Remainder takes the dividend's sign; quotient sign = XOR of the operand signs.
- Special cases (always override the result in FIX):
  - Divide by zero: quotient = all ones; remainder = dividend.
  - Signed overflow (-2^31 / -1): quotient = 0x80000000; remainder = 0.
- Arithmetic is modulo 2^DATA_WIDTH on the selected half; no flags are produced.

Optional Feature:
- Macro MDU_EARLY_EXIT_EN.
- Defined: PREP detects divide-by-zero, signed overflow, or a multiply operand equal to 0, and jumps directly to DONE with the final result loaded. done_o then asserts at cycle 2 and stall_o drops in cycle 2.
- Undefined: every operation takes the full 35-cycle path; special results are produced in FIX only. The FSM has no PREP->DONE arc.

Decomposition:
- Shared package mdu_pkg:
  - state encodings (IDLE, PREP, CALC, FIX, DONE);
  - funct3 operation codes;
  - M-extension funct7 constant 0000001;
  - DATA_WIDTH default.
- One sub-module, mdu_iter_core:
  - one multiply or divide step per enable;
  - holds the accumulator/product and quotient registers.
- mdu_sequencer keeps the FSM, counter, sign handling, special-case logic and output selection.

Test Plan:
1. MUL, rs1 = 7, rs2 = 0xFFFFFFFD (-3) -> result_o = 0xFFFFFFEB; done_o only at cycle 35; stall_o high cycles 0..34, low at 35.
2. MULH 0x80000000 x 0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
3. DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100 / 7 -> 14. REMU 100 / 7 -> 2.
4. Special cases, run with and without MDU_EARLY_EXIT_EN:
   - DIVU 5 / 0 -> 0xFFFFFFFF; REMU 5 / 0 -> 5.
   - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0.
   - Done at cycle 2 (defined) versus cycle 35 (undefined).
5. start_i held high through the operation and operands changed after cycle 1 -> second start ignored; single done_o pulse; result from the first operands. A new start at cycle 36 is accepted.
6. reset pulsed asynchronously at cycle 12 during CALC -> busy_o, done_o, stall_o and result_o go to 0 immediately. A subsequent DIVU 9 / 3 completes with 3.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer: FSM states,
// funct3 operation codes and the M-extension decode constants.
package mdu_pkg;

    localparam int DATA_WIDTH_DEF = 32;

    localparam logic [6:0] OPCODE_OP   = 7'b0110011;
    localparam logic [6:0] FUNCT7_MEXT = 7'b0000001;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREP,
        ST_CALC,
        ST_FIX,
        ST_DONE
    } mdu_state_t;

    typedef enum logic [2:0] {
        F3_MUL    = 3'b000,
        F3_MULH   = 3'b001,
        F3_MULHSU = 3'b010,
        F3_MULHU  = 3'b011,
        F3_DIV    = 3'b100,
        F3_DIVU   = 3'b101,
        F3_REM    = 3'b110,
        F3_REMU   = 3'b111
    } mdu_op_t;

    // Decoder helper: instruction belongs to the M extension.
    function automatic logic is_mext(input logic [6:0] opcode, input logic [6:0] funct7);
        return (opcode == OPCODE_OP) && (funct7 == FUNCT7_MEXT);
    endfunction

    function automatic logic op_is_div(input mdu_op_t op);
        return op[2];
    endfunction

endpackage

// File: rtl/mdu_iter_core.sv
// Iterative datapath: one unsigned shift-add multiply step or one restoring
// shift-subtract divide step per enabled cycle.
module mdu_iter_core #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         step,
    input  logic         is_div,
    input  logic [W-1:0] init_a,
    input  logic [W-1:0] init_b,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo
);

    // hi: product high half / partial remainder; lo: multiplier bits / quotient.
    logic [W-1:0] hi_reg, hi_next;
    logic [W-1:0] lo_reg, lo_next;
    logic [W-1:0] op_reg, op_next;
    logic [W:0]   rem_shift;
    logic [W+1:0] trial;
    logic [W:0]   sum;

    assign rem_shift = {hi_reg, lo_reg[W-1]};
    assign trial     = {1'b0, rem_shift} - {2'b00, op_reg};
    assign sum       = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, op_reg} : '0);

    always_comb begin
        hi_next = hi_reg;
        lo_next = lo_reg;
        op_next = op_reg;
        if (load) begin
            hi_next = '0;
            op_next = is_div ? init_b : init_a;
            lo_next = is_div ? init_a : init_b;
        end else if (step) begin
            if (is_div) begin
                // Borrow set means the trial subtraction failed: restore.
                if (trial[W+1]) begin
                    hi_next = rem_shift[W-1:0];
                    lo_next = {lo_reg[W-2:0], 1'b0};
                end else begin
                    hi_next = trial[W-1:0];
                    lo_next = {lo_reg[W-2:0], 1'b1};
                end
            end else begin
                {hi_next, lo_next} = {sum, lo_reg[W-1:1]};
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_reg <= '0;
            lo_reg <= '0;
            op_reg <= '0;
        end else begin
            hi_reg <= hi_next;
            lo_reg <= lo_next;
            op_reg <= op_next;
        end
    end

    assign hi = hi_reg;
    assign lo = lo_reg;

endmodule

// File: rtl/mdu_sequencer.sv
// RV32M multi-cycle sequencer: FSM, sign handling, special cases, result select.
// Optional macro MDU_EARLY_EXIT_EN lets PREP jump straight to DONE for trivial ops.
module mdu_sequencer
    import mdu_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int CNT_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic [2:0]            funct3_i,
    input  logic [DATA_WIDTH-1:0] rs1_data_i,
    input  logic [DATA_WIDTH-1:0] rs2_data_i,
    output logic                  stall_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] result_o
);

    localparam logic [DATA_WIDTH-1:0] MIN_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    mdu_state_t              state_reg, state_next;
    mdu_op_t                 funct3_reg;
    logic [DATA_WIDTH-1:0]   op_a_reg, op_b_reg, result_reg, fix_result;
    logic [CNT_WIDTH-1:0]    cnt_reg;
    logic                    is_div, a_signed, b_signed, a_neg, b_neg;
    logic                    div_zero, div_ovf, core_load, core_step;
    logic [DATA_WIDTH-1:0]   abs_a, abs_b, core_hi, core_lo, quot_fix, rem_fix;
    logic [2*DATA_WIDTH-1:0] prod_fix;

    assign is_div   = op_is_div(funct3_reg);
    assign a_signed = funct3_reg inside {F3_MULH, F3_MULHSU, F3_DIV, F3_REM};
    assign b_signed = funct3_reg inside {F3_MULH, F3_DIV, F3_REM};
    assign a_neg    = a_signed & op_a_reg[DATA_WIDTH-1];
    assign b_neg    = b_signed & op_b_reg[DATA_WIDTH-1];
    assign abs_a    = a_neg ? -op_a_reg : op_a_reg;
    assign abs_b    = b_neg ? -op_b_reg : op_b_reg;
    assign div_zero = is_div && (op_b_reg == '0);
    assign div_ovf  = is_div && b_signed && (op_a_reg == MIN_NEG) && (op_b_reg == '1);

    // Core works on magnitudes; signs are restored here after the last step.
    assign prod_fix = (a_neg ^ b_neg) ? -{core_hi, core_lo} : {core_hi, core_lo};
    assign quot_fix = (a_neg ^ b_neg) ? -core_lo : core_lo;
    assign rem_fix  = a_neg ? -core_hi : core_hi;

    always_comb begin
        fix_result = '0;
        case (funct3_reg)
            F3_MUL:                       fix_result = prod_fix[DATA_WIDTH-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: fix_result = prod_fix[2*DATA_WIDTH-1:DATA_WIDTH];
            F3_DIV, F3_DIVU:              fix_result = div_zero ? '1 : (div_ovf ? MIN_NEG : quot_fix);
            F3_REM, F3_REMU:              fix_result = div_zero ? op_a_reg : (div_ovf ? '0 : rem_fix);
            default:                      fix_result = '0;
        endcase
    end

`ifdef MDU_EARLY_EXIT_EN
    logic                  early_hit;
    logic [DATA_WIDTH-1:0] early_result;

    // Special divide results do not depend on the core, so fix_result is already final.
    assign early_hit    = div_zero || div_ovf || (!is_div && ((op_a_reg == '0) || (op_b_reg == '0)));
    assign early_result = is_div ? fix_result : '0;
`endif

    always_comb begin
        state_next = state_reg;
        stall_o    = 1'b0;
        busy_o     = (state_reg != ST_IDLE);
        done_o     = 1'b0;
        core_load  = 1'b0;
        core_step  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                stall_o = start_i;
                if (start_i) state_next = ST_PREP;
            end
            ST_PREP: begin
                stall_o   = 1'b1;
                core_load = 1'b1;
`ifdef MDU_EARLY_EXIT_EN
                state_next = early_hit ? ST_DONE : ST_CALC;
`else
                state_next = ST_CALC;
`endif
            end
            ST_CALC: begin
                stall_o   = 1'b1;
                core_step = 1'b1;
                if (cnt_reg == CNT_WIDTH'(DATA_WIDTH - 1)) state_next = ST_FIX;
            end
            ST_FIX: begin
                stall_o    = 1'b1;
                state_next = ST_DONE;
            end
            ST_DONE: begin
                done_o     = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= ST_IDLE;
            funct3_reg <= F3_MUL;
            op_a_reg   <= '0;
            op_b_reg   <= '0;
            cnt_reg    <= '0;
            result_reg <= '0;
        end else begin
            state_reg <= state_next;
            // Operands are captured on acceptance so later input changes are harmless.
            if (state_reg == ST_IDLE && start_i) begin
                funct3_reg <= mdu_op_t'(funct3_i);
                op_a_reg   <= rs1_data_i;
                op_b_reg   <= rs2_data_i;
            end
            if (state_reg == ST_PREP)      cnt_reg <= '0;
            else if (state_reg == ST_CALC) cnt_reg <= cnt_reg + 1'b1;
            if (state_reg == ST_FIX) result_reg <= fix_result;
`ifdef MDU_EARLY_EXIT_EN
            if (state_reg == ST_PREP && early_hit) result_reg <= early_result;
`endif
        end
    end

    assign result_o = result_reg;

    mdu_iter_core #(.W(DATA_WIDTH)) u_core (
        .clk    (clk),
        .reset  (reset),
        .load   (core_load),
        .step   (core_step),
        .is_div (is_div),
        .init_a (abs_a),
        .init_b (abs_b),
        .hi     (core_hi),
        .lo     (core_lo)
    );

endmodule

// File: tb/tb_mdu_sequencer.sv
// Self-checking bench for mdu_sequencer: directed and random RV32M operations
// against a 64-bit arithmetic reference model, plus timing, hold and reset checks.
module tb_mdu_sequencer;

    localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3;
    localparam logic [2:0] DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_i;
    logic [2:0]  funct3_i;
    logic [31:0] rs1_data_i, rs2_data_i;
    logic        stall_o, busy_o, done_o;
    logic [31:0] result_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mdu_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .start_i    (start_i),
        .funct3_i   (funct3_i),
        .rs1_data_i (rs1_data_i),
        .rs2_data_i (rs2_data_i),
        .stall_o    (stall_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .result_o   (result_o)
    );

    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ub;
        logic [63:0] p;
        int          ia, ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'h0, b});
        ia = $signed(a);
        ib = $signed(b);
        case (f3)
            MUL:    begin p = {32'h0, a} * {32'h0, b}; return p[31:0];  end
            MULH:   begin p = sa * sb;                 return p[63:32]; end
            MULHSU: begin p = sa * ub;                 return p[63:32]; end
            MULHU:  begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
            DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(ia / ib);
            end
            DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            REM: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return 32'(ia % ib);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int done_cycle(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
`ifdef MDU_EARLY_EXIT_EN
        bit special;
        if (f3[2]) special = (b == 0) || (f3 inside {DIV, REM} && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        else       special = (a == 0) || (b == 0);
        return special ? 2 : 35;
`else
        return 35;
`endif
    endfunction

    // Starts at the next negedge (cycle 0) and returns after checking the done cycle.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input bit hold_start, input string tag);
        int          dc;
        logic [31:0] exp;
        dc  = done_cycle(f3, a, b);
        exp = model(f3, a, b);
        @(negedge clk);
        start_i = 1'b1; funct3_i = f3; rs1_data_i = a; rs2_data_i = b;
        for (int c = 0; c <= dc; c++) begin
            if (c > 0) begin
                @(negedge clk);
                start_i = hold_start;
                if (hold_start && c >= 2) begin
                    rs1_data_i = $urandom; rs2_data_i = $urandom; funct3_i = 3'($urandom);
                end
            end
            #1;
            checks++;
            if (stall_o !== 1'(c < dc)) begin
                errors++; $display("FAIL %s stall cycle %0d got %b exp %b", tag, c, stall_o, c < dc);
            end
            checks++;
            if (done_o !== 1'(c == dc)) begin
                errors++; $display("FAIL %s done cycle %0d got %b exp %b", tag, c, done_o, c == dc);
            end
            checks++;
            if (busy_o !== 1'(c >= 1)) begin
                errors++; $display("FAIL %s busy cycle %0d got %b exp %b", tag, c, busy_o, c >= 1);
            end
        end
        checks++;
        if (result_o !== exp) begin
            errors++; $display("FAIL %s result f3=%0d a=%h b=%h got %h exp %h", tag, f3, a, b, result_o, exp);
        end
        $display("%s f3=%0d a=%h b=%h result=%h expected=%h done_cycle=%0d", tag, f3, a, b, result_o, exp, dc);
    endtask

    task automatic test_reset();
        reset = 1'b1; start_i = 1'b0; funct3_i = '0; rs1_data_i = '0; rs2_data_i = '0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({busy_o, done_o, stall_o} !== 3'b000 || result_o !== 32'h0) begin
            errors++; $display("FAIL reset outputs got b%b d%b s%b r=%h exp 0", busy_o, done_o, stall_o, result_o);
        end
        reset = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (busy_o !== 1'b0 || stall_o !== 1'b0) begin
            errors++; $display("FAIL idle_after_reset got busy %b stall %b exp 0 0", busy_o, stall_o);
        end
        $display("reset check done");
    endtask

    task automatic test_directed();
        logic [2:0]  f3s [12] = '{MUL, MULH, MULHU, MULHSU, DIV, REM, DIVU, REMU, DIVU, REMU, DIV, REM};
        logic [31:0] as  [12] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9,
                                  32'hFFFF_FFF9, 32'd100, 32'd100, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] bs  [12] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'd2, 32'd2,
                                  32'd2, 32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        for (int i = 0; i < 12; i++) run_op(f3s[i], as[i], bs[i], 1'b0, "directed");
    endtask

    function automatic logic [31:0] pick_operand(input bit allow_zero);
        logic [31:0] edges [5] = '{32'h0, 32'h1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
        int          r;
        r = $urandom_range(0, 3);
        if (r == 0) begin
            r = $urandom_range(allow_zero ? 0 : 1, 4);
            return edges[r];
        end
        return $urandom;
    endfunction

    task automatic test_mul_random();
        for (int i = 0; i < 8; i++)
            run_op(3'($urandom_range(0, 3)), pick_operand(1'b1), pick_operand(1'b1), 1'b0, "mul_rand");
    endtask

    task automatic test_div_random();
        logic [31:0] b;
        for (int i = 0; i < 8; i++) begin
            b = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 9)) : pick_operand(1'b1);
            run_op(3'($urandom_range(4, 7)), pick_operand(1'b1), b, 1'b0, "div_rand");
        end
    endtask

    task automatic test_back_to_back();
        run_op(MULHU, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, "hold_start");
        run_op(DIVU, 32'd1000, 32'd33, 1'b0, "back_to_back");
    endtask

    task automatic test_reset_abort();
        @(negedge clk);
        start_i = 1'b1; funct3_i = MUL; rs1_data_i = 32'hDEAD_BEEF; rs2_data_i = 32'h0000_1235;
        @(negedge clk);
        start_i = 1'b0;
        repeat (11) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({busy_o, done_o, stall_o} !== 3'b000 || result_o !== 32'h0) begin
            errors++; $display("FAIL abort_reset got b%b d%b s%b r=%h exp 0", busy_o, done_o, stall_o, result_o);
        end
        #1 reset = 1'b0;
        $display("reset abort at cycle 12 checked");
        run_op(DIVU, 32'd9, 32'd3, 1'b0, "after_abort");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_mul_random();
        test_div_random();
        test_back_to_back();
        test_reset_abort();
        start_i = 1'b0;
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
